// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for execute-stage ALU control and the iterative multiply/divide engine.
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    SelAnd  = 4'b0000,
    SelOr   = 4'b0001,
    SelAdd  = 4'b0010,
    SelX    = 4'b0011,
    SelXor  = 4'b0100,
    SelNor  = 4'b0101,
    SelSub  = 4'b0110,
    SelSlt  = 4'b0111,
    SelSll  = 4'b1000,
    SelSrl  = 4'b1001,
    SelSra  = 4'b1010,
    SelSltu = 4'b1011
  } alu_sel_e;

  typedef enum logic [1:0] {
    AluopMem     = 2'b00,
    AluopBranch  = 2'b01,
    AluopRtype   = 2'b10,
    AluopUnknown = 2'b11
  } aluop_e;

  localparam logic [5:0] FunctSll   = 6'b000000;
  localparam logic [5:0] FunctSrl   = 6'b000010;
  localparam logic [5:0] FunctSra   = 6'b000011;
  localparam logic [5:0] FunctMfhi  = 6'b010000;
  localparam logic [5:0] FunctMflo  = 6'b010010;
  localparam logic [5:0] FunctMult  = 6'b011000;
  localparam logic [5:0] FunctMultu = 6'b011001;
  localparam logic [5:0] FunctDiv   = 6'b011010;
  localparam logic [5:0] FunctDivu  = 6'b011011;
  localparam logic [5:0] FunctAdd   = 6'b100000;
  localparam logic [5:0] FunctSub   = 6'b100010;
  localparam logic [5:0] FunctAnd   = 6'b100100;
  localparam logic [5:0] FunctOr    = 6'b100101;
  localparam logic [5:0] FunctXor   = 6'b100110;
  localparam logic [5:0] FunctNor   = 6'b100111;
  localparam logic [5:0] FunctSlt   = 6'b101010;
  localparam logic [5:0] FunctSltu  = 6'b101011;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StFix
  } md_state_e;

  // mult/multu/div/divu share the 0110xx prefix; the low two bits select the op.
  function automatic logic is_muldiv(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative radix-2 shift-add multiplier / restoring divider with sign fix-up cycle.
module muldiv_iter
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             div_q, div_d;

  logic             sgn;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   sum, shifted, diff;
  logic [2*WIDTH-1:0] prod;

  // op[0] set means the unsigned variant, op[1] set means divide.
  assign sgn     = ~op[0];
  assign abs_a   = (sgn & a[WIDTH-1]) ? -a : a;
  assign abs_b   = (sgn & b[WIDTH-1]) ? -b : b;
  assign sum     = {1'b0, acc_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
  assign shifted = {acc_q, lo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, opnd_q};
  assign prod    = neg_q ? -{acc_q, lo_q} : {acc_q, lo_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    div_d   = div_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d = CNT_W'(WIDTH - 1);
          div_d = op[1];
          neg_d = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
          if (op[1]) begin
            acc_d  = '0;
            lo_d   = abs_a;
            opnd_d = abs_b;
            rneg_d = sgn & a[WIDTH-1];
            if (b == '0) begin
              // Remainder fix-up restores the original dividend into HI.
              acc_d   = abs_a;
              lo_d    = '1;
              neg_d   = 1'b0;
              state_d = StFix;
            end else begin
              state_d = StDiv;
            end
          end else begin
            acc_d   = '0;
            lo_d    = abs_b;
            opnd_d  = abs_a;
            rneg_d  = 1'b0;
            state_d = StMul;
          end
        end
      end
      StMul: begin
        acc_d = sum[WIDTH:1];
        lo_d  = {sum[0], lo_q[WIDTH-1:1]};
        if (cnt_q == '0) state_d = StFix;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StDiv: begin
        if (!diff[WIDTH]) begin
          acc_d = diff[WIDTH-1:0];
          lo_d  = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = shifted[WIDTH-1:0];
          lo_d  = {lo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) state_d = StFix;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StFix: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    busy = state_q != StIdle;
    done = state_q == StFix;
    if (div_q) begin
      res_lo = neg_q ? -lo_q : lo_q;
      res_hi = rneg_q ? -acc_q : acc_q;
    end else begin
      res_lo = prod[WIDTH-1:0];
      res_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      div_q   <= div_d;
    end
  end

endmodule

// File: rtl/alu_muldiv_control.sv
// Execute-stage ALU select decode, HI/LO ownership and stall control around muldiv_iter.
module alu_muldiv_control
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [5:0]       funct,
  input  logic [1:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       select,
  output logic             hilo_sel,
  output logic [WIDTH-1:0] hilo_data,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic             is_rtype, is_md, is_hilo_rd, start, done;
  logic [WIDTH-1:0] hi_q, lo_q, res_hi, res_lo;

  assign is_rtype   = aluop == AluopRtype;
  assign is_md      = is_rtype & is_muldiv(funct);
  assign is_hilo_rd = is_rtype & ((funct == FunctMfhi) | (funct == FunctMflo));
  assign start      = valid & is_md & ~busy;
  // Busy covers the FIX cycle, so readers wait until HI/LO have been written.
  assign stall      = valid & busy & (is_md | is_hilo_rd);

  always_comb begin
    select   = SelX;
    hilo_sel = 1'b0;
    unique case (aluop)
      AluopMem:     select = SelAdd;
      AluopBranch:  select = SelSub;
      AluopUnknown: select = SelX;
      AluopRtype: begin
        case (funct)
          FunctAdd:  select = SelAdd;
          FunctSub:  select = SelSub;
          FunctAnd:  select = SelAnd;
          FunctOr:   select = SelOr;
          FunctXor:  select = SelXor;
          FunctNor:  select = SelNor;
          FunctSlt:  select = SelSlt;
          FunctSltu: select = SelSltu;
          FunctSll:  select = SelSll;
          FunctSrl:  select = SelSrl;
          FunctSra:  select = SelSra;
          FunctMfhi, FunctMflo: begin
            select   = SelX;
            hilo_sel = 1'b1;
          end
          default:   select = SelX;
        endcase
      end
    endcase
  end

  assign hilo_data = (funct == FunctMfhi) ? hi_q : lo_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

  muldiv_iter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_muldiv_iter (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (funct[1:0]),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .res_hi(res_hi),
    .res_lo(res_lo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (done) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_control.sv
// Self-checking bench: decode sweep plus scoreboarded multiply/divide, stall and reset scenarios.
module tb_alu_muldiv_control;

  localparam logic [5:0] FMult  = 6'b011000;
  localparam logic [5:0] FMultu = 6'b011001;
  localparam logic [5:0] FDiv   = 6'b011010;
  localparam logic [5:0] FDivu  = 6'b011011;
  localparam logic [5:0] FMfhi  = 6'b010000;
  localparam logic [5:0] FMflo  = 6'b010010;

  logic        clk, rst, valid;
  logic [5:0]  funct;
  logic [1:0]  aluop;
  logic [31:0] a, b;
  logic [3:0]  select;
  logic        hilo_sel, stall, busy;
  logic [31:0] hilo_data, hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0] op;
    logic [5:0] f;
    logic [3:0] sel;
    logic       hs;
  } dec_t;

  int errors, checks;

  alu_muldiv_control #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid    (valid),
    .funct    (funct),
    .aluop    (aluop),
    .a        (a),
    .b        (b),
    .select   (select),
    .hilo_sel (hilo_sel),
    .hilo_data(hilo_data),
    .stall    (stall),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] h, output logic [31:0] l);
    logic [63:0] p;
    p = '0;
    h = '0;
    l = '0;
    case (f)
      FMult: begin
        p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        {h, l} = p;
      end
      FMultu: begin
        p = {32'd0, x} * {32'd0, y};
        {h, l} = p;
      end
      FDiv: begin
        if (y == 32'd0) begin
          h = x;
          l = 32'hFFFF_FFFF;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          h = 32'd0;
          l = 32'h8000_0000;
        end else begin
          l = $signed(x) / $signed(y);
          h = $signed(x) % $signed(y);
        end
      end
      default: begin
        if (y == 32'd0) begin
          h = x;
          l = 32'hFFFF_FFFF;
        end else begin
          l = x / y;
          h = x % y;
        end
      end
    endcase
  endfunction

  // Counts busy cycles from the current cycle, then pops and compares the scoreboard entry.
  task automatic wait_result(input string tag);
    exp_t e;
    int n, st;
    n  = 0;
    st = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (stall) st++;
      @(posedge clk);
      #1;
    end
    e = sb.pop_front();
    check($sformatf("%s busy_cycles", tag), 64'(n), 64'(e.cycles));
    check($sformatf("%s hi", tag), {32'd0, hi}, {32'd0, e.hi});
    check($sformatf("%s lo", tag), {32'd0, lo}, {32'd0, e.lo});
    check($sformatf("%s idle_reader_stalls", tag), 64'(st), 64'd0);
    next_cycle();
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] xa,
                        input logic [31:0] xb, input logic [31:0] eh, input logic [31:0] el,
                        input int ecyc);
    exp_t e;
    e.hi = eh;
    e.lo = el;
    e.cycles = ecyc;
    sb.push_back(e);
    valid = 1'b1;
    aluop = 2'b10;
    funct = f;
    a = xa;
    b = xb;
    @(negedge clk);
    check($sformatf("%s issue_stall", tag), {63'd0, stall}, 64'd0);
    next_cycle();
    // A bubble carrying mfhi must neither stall nor disturb the running op.
    valid = 1'b0;
    funct = FMfhi;
    wait_result(tag);
  endtask

  dec_t dec_tab[19] = '{
    '{2'b10, 6'b100000, 4'b0010, 1'b0}, '{2'b10, 6'b100010, 4'b0110, 1'b0},
    '{2'b10, 6'b100100, 4'b0000, 1'b0}, '{2'b10, 6'b100101, 4'b0001, 1'b0},
    '{2'b10, 6'b100110, 4'b0100, 1'b0}, '{2'b10, 6'b100111, 4'b0101, 1'b0},
    '{2'b10, 6'b101010, 4'b0111, 1'b0}, '{2'b10, 6'b101011, 4'b1011, 1'b0},
    '{2'b10, 6'b000000, 4'b1000, 1'b0}, '{2'b10, 6'b000010, 4'b1001, 1'b0},
    '{2'b10, 6'b000011, 4'b1010, 1'b0}, '{2'b10, 6'b111111, 4'b0011, 1'b0},
    '{2'b10, 6'b010000, 4'b0011, 1'b1}, '{2'b10, 6'b010010, 4'b0011, 1'b1},
    '{2'b10, 6'b011000, 4'b0011, 1'b0}, '{2'b00, 6'b100010, 4'b0010, 1'b0},
    '{2'b01, 6'b100000, 4'b0110, 1'b0}, '{2'b11, 6'b100000, 4'b0011, 1'b0},
    '{2'b00, 6'b010000, 4'b0010, 1'b0}
  };

  initial begin
    exp_t e;
    logic [31:0] mh, ml;
    logic [5:0]  rf;
    logic [31:0] ra, rb;
    int n;

    errors = 0;
    checks = 0;
    rst = 1'b1;
    valid = 1'b0;
    aluop = 2'b00;
    funct = 6'd0;
    a = '0;
    b = '0;
    #12;
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset stall", {63'd0, stall}, 64'd0);
    check("reset hi", {32'd0, hi}, 64'd0);
    check("reset lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    next_cycle();

    foreach (dec_tab[i]) begin
      aluop = dec_tab[i].op;
      funct = dec_tab[i].f;
      #1;
      check($sformatf("decode%0d select", i), {60'd0, select}, {60'd0, dec_tab[i].sel});
      check($sformatf("decode%0d hilo_sel", i), {63'd0, hilo_sel}, {63'd0, dec_tab[i].hs});
    end
    next_cycle();

    run_op("multu_max", FMultu, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 33);
    run_op("mult_neg", FMult, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33);
    run_op("div_neg", FDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_op("divu_zero", FDivu, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1);
    run_op("div_zero_neg", FDiv, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1);
    run_op("div_ovf", FDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);

    for (int i = 0; i < 6; i++) begin
      rf = {4'b0110, 2'($urandom_range(0, 3))};
      ra = $urandom;
      rb = (i == 2) ? 32'($urandom_range(1, 15)) : $urandom;
      model(rf, ra, rb, mh, ml);
      run_op($sformatf("rand%0d", i), rf, ra, rb, mh, ml, 33);
    end

    // mflo behind a mult: stalls through FIX, then sees the new LO.
    model(FMult, 32'd1234567, 32'hFFFF_FF00, mh, ml);
    e.hi = mh;
    e.lo = ml;
    e.cycles = 0;
    sb.push_back(e);
    valid = 1'b1;
    aluop = 2'b10;
    funct = FMult;
    a = 32'd1234567;
    b = 32'hFFFF_FF00;
    @(negedge clk);
    check("mflo_seq issue_stall", {63'd0, stall}, 64'd0);
    next_cycle();
    funct = FMflo;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
      @(posedge clk);
      #1;
    end
    e = sb.pop_front();
    check("mflo_seq stall_cycles", 64'(n), 64'd33);
    check("mflo_seq hilo_sel", {63'd0, hilo_sel}, 64'd1);
    check("mflo_seq hilo_data", {32'd0, hilo_data}, {32'd0, e.lo});
    check("mflo_seq hi", {32'd0, hi}, {32'd0, e.hi});
    next_cycle();

    // Second mult presented while busy stalls and must not restart the engine.
    e.hi = 32'd0;
    e.lo = 32'd42;
    e.cycles = 31;
    sb.push_back(e);
    funct = FMult;
    a = 32'd7;
    b = 32'd6;
    @(negedge clk);
    check("mult_busy first_issue_stall", {63'd0, stall}, 64'd0);
    next_cycle();
    a = 32'd2;
    b = 32'd2;
    @(negedge clk);
    check("mult_busy stall", {63'd0, stall}, 64'd1);
    next_cycle();
    valid = 1'b0;
    next_cycle();
    wait_result("mult_busy");

    // Asynchronous reset in the middle of a divide.
    valid = 1'b1;
    aluop = 2'b10;
    funct = FDivu;
    a = 32'd1000;
    b = 32'd3;
    next_cycle();
    funct = FMfhi;
    for (int i = 0; i < 9; i++) next_cycle();
    check("abort pre_stall", {63'd0, stall}, 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("abort busy", {63'd0, busy}, 64'd0);
    check("abort stall", {63'd0, stall}, 64'd0);
    check("abort hi", {32'd0, hi}, 64'd0);
    check("abort lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    valid = 1'b0;
    next_cycle();
    run_op("divu_after_rst", FDivu, 32'd100, 32'd7, 32'd2, 32'd14, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
